// File: rtl/reaction_timer_ctrl_if.sv
// Signal bundle between the reaction-time sequencer and the rest of top:
// ms strobe, LFSR and button in; BCD-counter controls, LEDs and results out.
interface reaction_timer_ctrl_if #(
  parameter int W = 14
);
  logic         tick_ms;
  logic         btn_n;
  logic [14:0]  rand_num;
  logic         cnt_clr;
  logic         cnt_inc;
  logic         led_go;
  logic         led_foul;
  logic [W-1:0] result_ms;
  logic [W-1:0] best_ms;
  logic         new_best;
  logic [2:0]   state;

  modport master (
    output tick_ms,
    output btn_n,
    output rand_num,
    input  cnt_clr,
    input  cnt_inc,
    input  led_go,
    input  led_foul,
    input  result_ms,
    input  best_ms,
    input  new_best,
    input  state
  );

  modport slave (
    input  tick_ms,
    input  btn_n,
    input  rand_num,
    output cnt_clr,
    output cnt_inc,
    output led_go,
    output led_foul,
    output result_ms,
    output best_ms,
    output new_best,
    output state
  );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game sequencer: random wait, GO, ms counting, foul and
// timeout handling, last/best result tracking. All outputs registered.
module reaction_timer_ctrl #(
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int MAX_MS       = 9999,
  parameter int W            = 14
) (
  input  logic                  ADC_CLK_10,
  input  logic                  rst,
  reaction_timer_ctrl_if.slave  io
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    GO    = 3'd2,
    DONE  = 3'd3,
    FOUL  = 3'd4
  } state_e;

  localparam logic [W-1:0] MAX_W = W'(MAX_MS);
  localparam logic [W-1:0] MIN_W = W'(MIN_DELAY_MS);
  localparam logic [W-1:0] ONE_W = W'(1);

  state_e       state_q;
  logic         s1_q;
  logic         s2_q;
  logic         prev_q;
  logic         press;
  logic [W-1:0] delay_q;
  logic [W-1:0] ms_q;
  logic [W-1:0] result_q;
  logic [W-1:0] best_q;
  logic         clr_q;
  logic         inc_q;
  logic         nb_q;
  logic         go_q;
  logic         foul_q;
  logic [W-1:0] load_val;

  // Button is asynchronous; released level is 1 so reset never fakes a press
  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= io.btn_n;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign press    = ~s2_q & prev_q;
  assign load_val = MIN_W + W'(io.rand_num[RAND_BITS-1:0]);

  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      delay_q  <= '0;
      ms_q     <= '0;
      result_q <= '0;
      best_q   <= MAX_W;
      clr_q    <= 1'b0;
      inc_q    <= 1'b0;
      nb_q     <= 1'b0;
      go_q     <= 1'b0;
      foul_q   <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      inc_q <= 1'b0;
      nb_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (press) begin
            delay_q <= load_val;
            ms_q    <= '0;
            clr_q   <= 1'b1;
            state_q <= ARMED;
          end
        end
        ARMED: begin
          // An early press is a foul even if a tick lands the same cycle
          if (press) begin
            foul_q  <= 1'b1;
            state_q <= FOUL;
          end else if (io.tick_ms) begin
            if (delay_q == ONE_W) begin
              go_q    <= 1'b1;
              state_q <= GO;
            end else begin
              delay_q <= delay_q - ONE_W;
            end
          end
        end
        GO: begin
          if (press) begin
            result_q <= ms_q;
            go_q     <= 1'b0;
            state_q  <= DONE;
            if (ms_q < best_q) begin
              best_q <= ms_q;
              nb_q   <= 1'b1;
            end
          end else if (io.tick_ms) begin
            inc_q <= 1'b1;
            if (ms_q >= MAX_W - ONE_W) begin
              ms_q     <= MAX_W;
              result_q <= MAX_W;
              go_q     <= 1'b0;
              state_q  <= DONE;
            end else begin
              ms_q <= ms_q + ONE_W;
            end
          end
        end
        DONE, FOUL: begin
          if (press) begin
            delay_q <= load_val;
            ms_q    <= '0;
            clr_q   <= 1'b1;
            foul_q  <= 1'b0;
            state_q <= ARMED;
          end
        end
        default: begin
          go_q    <= 1'b0;
          foul_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign io.cnt_clr   = clr_q;
  assign io.cnt_inc   = inc_q;
  assign io.led_go    = go_q;
  assign io.led_foul  = foul_q;
  assign io.result_ms = result_q;
  assign io.best_ms   = best_q;
  assign io.new_best  = nb_q;
  assign io.state     = state_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl: scoreboard of expected results
// popped on each DONE entry, plus pulse counters checked per round.
module tb_reaction_timer_ctrl;
  localparam int W = 14;

  typedef struct {
    int res;
    int best;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;
  int   inc_cnt;
  int   clr_cnt;
  int   nb_cnt;
  logic [2:0] prev_st;

  reaction_timer_ctrl_if #(.W(W)) io ();

  reaction_timer_ctrl #(
    .MIN_DELAY_MS(1000),
    .RAND_BITS(11),
    .MAX_MS(9999),
    .W(W)
  ) dut (
    .ADC_CLK_10(clk),
    .rst(rst),
    .io(io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse counting and scoreboard pop, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      prev_st = 3'd0;
    end else begin
      if (io.cnt_inc === 1'b1) inc_cnt++;
      if (io.cnt_clr === 1'b1) clr_cnt++;
      if (io.new_best === 1'b1) nb_cnt++;
      if (io.cnt_clr || io.cnt_inc)
        chk("clr_inc_excl", 32'(io.cnt_clr & io.cnt_inc), 0);
      if (io.state == 3'd3 && prev_st != 3'd3) begin
        chk("sb_depth", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_result", 32'(io.result_ms), e.res);
          chk("sb_best", 32'(io.best_ms), e.best);
        end
      end
      prev_st = io.state;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      io.tick_ms = 1'b1;
      cyc();
      io.tick_ms = 1'b0;
      cyc();
    end
  endtask

  task automatic press(input int hold);
    io.btn_n = 1'b0;
    repeat (hold) cyc();
    io.btn_n = 1'b1;
    repeat (4) cyc();
  endtask

  task automatic push(input int r, input int b);
    exp_t e;
    e.res  = r;
    e.best = b;
    sb_q.push_back(e);
  endtask

  initial begin
    int inc0;
    int clr0;
    int nb0;
    n_cmp = 0;
    n_bad = 0;
    inc_cnt = 0;
    clr_cnt = 0;
    nb_cnt = 0;
    prev_st = 3'd0;
    rst = 1'b1;
    io.tick_ms = 1'b0;
    io.btn_n = 1'b1;
    io.rand_num = 15'h0;
    repeat (3) cyc();
    chk("rst_state", 32'(io.state), 0);
    chk("rst_result", 32'(io.result_ms), 0);
    chk("rst_best", 32'(io.best_ms), 9999);
    chk("rst_led_go", 32'(io.led_go), 0);
    chk("rst_led_foul", 32'(io.led_foul), 0);
    chk("rst_clr", 32'(io.cnt_clr), 0);
    chk("rst_inc", 32'(io.cnt_inc), 0);
    chk("rst_new_best", 32'(io.new_best), 0);
    rst = 1'b0;
    cyc();

    // Round 1: delay 1005, react after 237 ticks
    io.rand_num = 15'h7805;
    clr0 = clr_cnt;
    press(3);
    io.rand_num = 15'h07FF;
    chk("r1_clr_pulses", 32'(clr_cnt - clr0), 1);
    chk("r1_armed", 32'(io.state), 1);
    ticks(1004);
    chk("r1_not_go_yet", 32'(io.state), 1);
    chk("r1_led_go_low", 32'(io.led_go), 0);
    ticks(1);
    chk("r1_go", 32'(io.state), 2);
    chk("r1_led_go", 32'(io.led_go), 1);
    inc0 = inc_cnt;
    nb0 = nb_cnt;
    ticks(237);
    push(237, 237);
    press(3);
    chk("r1_done", 32'(io.state), 3);
    chk("r1_led_go_off", 32'(io.led_go), 0);
    chk("r1_inc_pulses", 32'(inc_cnt - inc0), 237);
    chk("r1_new_best", 32'(nb_cnt - nb0), 1);

    // Foul round
    io.rand_num = 15'h0000;
    clr0 = clr_cnt;
    press(3);
    chk("f_clr", 32'(clr_cnt - clr0), 1);
    inc0 = inc_cnt;
    ticks(500);
    press(3);
    chk("f_state", 32'(io.state), 4);
    chk("f_led_foul", 32'(io.led_foul), 1);
    chk("f_no_inc", 32'(inc_cnt - inc0), 0);
    ticks(3);
    chk("f_tick_ignored", 32'(io.state), 4);
    clr0 = clr_cnt;
    press(3);
    chk("f_rearm", 32'(io.state), 1);
    chk("f_rearm_clr", 32'(clr_cnt - clr0), 1);
    chk("f_led_foul_off", 32'(io.led_foul), 0);

    // Timeout round (delay 1000 loaded by the re-arm press)
    ticks(1000);
    chk("t_go", 32'(io.state), 2);
    inc0 = inc_cnt;
    nb0 = nb_cnt;
    push(9999, 237);
    ticks(9998);
    chk("t_still_go", 32'(io.state), 2);
    ticks(1);
    chk("t_done", 32'(io.state), 3);
    chk("t_result", 32'(io.result_ms), 9999);
    chk("t_inc_pulses", 32'(inc_cnt - inc0), 9999);
    chk("t_no_new_best", 32'(nb_cnt - nb0), 0);
    ticks(5);
    chk("t_no_more_inc", 32'(inc_cnt - inc0), 9999);

    // Press coinciding with a tick at ms_cnt=42
    press(3);
    ticks(1000);
    chk("c_go", 32'(io.state), 2);
    inc0 = inc_cnt;
    nb0 = nb_cnt;
    ticks(42);
    push(42, 42);
    io.btn_n = 1'b0;
    cyc();
    cyc();
    io.tick_ms = 1'b1;
    cyc();
    io.tick_ms = 1'b0;
    cyc();
    io.btn_n = 1'b1;
    repeat (4) cyc();
    chk("c_done", 32'(io.state), 3);
    chk("c_result", 32'(io.result_ms), 42);
    chk("c_inc_pulses", 32'(inc_cnt - inc0), 42);
    chk("c_new_best", 32'(nb_cnt - nb0), 1);

    // Slower round: best must hold at 42
    press(3);
    ticks(1000);
    nb0 = nb_cnt;
    ticks(300);
    push(300, 42);
    press(3);
    chk("s_result", 32'(io.result_ms), 300);
    chk("s_best", 32'(io.best_ms), 42);
    chk("s_no_new_best", 32'(nb_cnt - nb0), 0);

    // Held button gives a single press
    clr0 = clr_cnt;
    press(1000);
    chk("h_armed", 32'(io.state), 1);
    chk("h_single_clr", 32'(clr_cnt - clr0), 1);

    // Asynchronous reset mid-GO
    ticks(1000);
    chk("r_go", 32'(io.state), 2);
    ticks(50);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("r_state", 32'(io.state), 0);
    chk("r_best", 32'(io.best_ms), 9999);
    chk("r_led_go", 32'(io.led_go), 0);
    chk("r_result", 32'(io.result_ms), 0);
    cyc();
    rst = 1'b0;
    ticks(20);
    chk("r_stay_idle", 32'(io.state), 0);

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
